// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V controller: opcodes, FSM states and
// datapath mux selects.
package riscv_pkg;

    localparam logic [6:0] OpcOp    = 7'b0110011;
    localparam logic [6:0] OpcOpImm = 7'b0010011;
    localparam logic [6:0] OpcLoad  = 7'b0000011;
    localparam logic [6:0] OpcStore = 7'b0100011;

    typedef enum logic [2:0] {
        StFetch  = 3'd0,
        StDecode = 3'd1,
        StExec   = 3'd2,
        StWbAlu  = 3'd3,
        StAddr   = 3'd4,
        StMem    = 3'd5,
        StWbMem  = 3'd6,
        StTrap   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        ImmNone = 2'd0,
        ImmI    = 2'd1,
        ImmS    = 2'd2
    } imm_sel_e;

    typedef enum logic [1:0] {
        SrcBRs2  = 2'd0,
        SrcBImm  = 2'd1,
        SrcBFour = 2'd2
    } alu_src_b_e;

endpackage

// File: rtl/multicycle_controller.sv
// Multicycle control FSM for an RV32 subset (OP, OP-IMM, LOAD, STORE); unsupported
// opcodes park the FSM in TRAP until reset.
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        addr_sel,
    output logic        pc_we,
    output logic        ir_we,
    output logic [1:0]  imm_sel,
    output logic [1:0]  alu_src_b,
    output logic        rf_we,
    output logic        wb_sel,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [15:0] retired
);

    state_e      state_q, state_d;
    logic [15:0] retired_q, retired_d;
    logic        illegal_q, illegal_d;

    logic        mem_req_c, pc_we_c, ir_we_c, rf_we_c;
    logic        retire;
    imm_sel_e    imm_sel_c;
    alu_src_b_e  alu_src_b_c;

    logic [6:0]  opcode;
    logic        is_store;

    assign opcode   = instr[6:0];
    assign is_store = (opcode == OpcStore);

    always_comb begin
        state_d     = state_q;
        mem_req_c   = 1'b0;
        mem_we      = 1'b0;
        addr_sel    = 1'b0;
        pc_we_c     = 1'b0;
        ir_we_c     = 1'b0;
        imm_sel_c   = ImmNone;
        alu_src_b_c = SrcBRs2;
        rf_we_c     = 1'b0;
        wb_sel      = 1'b0;
        retire      = 1'b0;

        unique case (state_q)
            StFetch: begin
                mem_req_c   = 1'b1;
                alu_src_b_c = SrcBFour;
                ir_we_c     = mem_ready;
                pc_we_c     = mem_ready;
                if (mem_ready) begin
                    state_d = StDecode;
                end
            end
            StDecode: begin
                if (opcode == OpcOp || opcode == OpcOpImm) begin
                    state_d = StExec;
                end else if (opcode == OpcLoad || opcode == OpcStore) begin
                    state_d = StAddr;
                end else begin
                    state_d = StTrap;
                end
            end
            StExec: begin
                if (opcode == OpcOpImm) begin
                    alu_src_b_c = SrcBImm;
                    imm_sel_c   = ImmI;
                end
                state_d = StWbAlu;
            end
            StWbAlu: begin
                rf_we_c = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StAddr: begin
                alu_src_b_c = SrcBImm;
                imm_sel_c   = is_store ? ImmS : ImmI;
                state_d     = StMem;
            end
            StMem: begin
                mem_req_c = 1'b1;
                addr_sel  = 1'b1;
                mem_we    = is_store;
                imm_sel_c = is_store ? ImmS : ImmI;
                if (mem_ready) begin
                    // Stores have no write-back, so they retire on memory completion.
                    if (is_store) begin
                        retire  = 1'b1;
                        state_d = StFetch;
                    end else begin
                        state_d = StWbMem;
                    end
                end
            end
            StWbMem: begin
                rf_we_c = 1'b1;
                wb_sel  = 1'b1;
                retire  = 1'b1;
                state_d = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    always_comb begin
        retired_d = retired_q;
        if (retire) begin
            retired_d = retired_q + 16'd1;
        end
        illegal_d = illegal_q | (state_d == StTrap);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StFetch;
            retired_q <= 16'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset parks the FSM in FETCH, whose request/strobes must stay quiet while rst is held.
    assign mem_req   = mem_req_c & ~rst;
    assign pc_we     = pc_we_c & ~rst;
    assign ir_we     = ir_we_c & ~rst;
    assign rf_we     = rf_we_c & ~rst;
    assign imm_sel   = imm_sel_c;
    assign alu_src_b = alu_src_b_c;
    assign illegal   = illegal_q;
    assign state     = state_q;
    assign retired   = retired_q;

endmodule
